bmp_header_parser: RTL and testbench
====================================

Name: bmp_header_parser

Overview:
Reads a 24-bit uncompressed BMP header from byte-addressed memory, one byte per address in the low 8 bits of each 16-bit word. It extracts the image geometry and validates the fields the cropping path supports. It is the read-side counterpart of the header generator and runs before the crop engine, which consumes width/height/stride/offset. It issues a single non-pipelined read at a time against a fixed-latency memory port.

Parameters:
RD_LATENCY, 1, cycles from the rden cycle to valid rddata (1..4)
MAX_WIDTH, 2047, largest accepted width in pixels (must fit 11 bits)
MAX_HEIGHT, 2047, largest accepted absolute height in pixels (must fit 11 bits)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  begin parse; sampled only in IDLE or DONE
base_addr  in  24  address of header byte 0; latched when start is accepted
addr  out  24  read address = latched base + byte index
rden  out  1  read strobe, one cycle per byte
rddata  in  16  read data; bits [7:0] are the byte, [15:8] are ignored
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE; stays high until the next start is accepted
error  out  4  result code, valid while done=1
width  out  11  image width in pixels
height  out  11  absolute image height in pixels
top_down  out  1  1 when the header height field is negative
data_offset  out  32  pixel data offset (header bytes 10-13)
row_stride  out  13  padded row size in bytes = (3*width+3) & ~3

Behaviour:
- Reset: state IDLE. addr, rden, busy, done, error, width, height, top_down, data_offset and row_stride are all 0. Byte index = 0.
- States:
  - IDLE: start=1 -> REQ. Latch base_addr, index=0.
  - REQ: rden=1, addr=base+index. Next state is WAIT.
  - WAIT: count RD_LATENCY cycles. On the final count edge, capture rddata[7:0] into the field register selected by index.
    - index<37: index++, -> REQ.
    - index=37: -> CHECK.
  - CHECK: one cycle. Validate fields and compute outputs -> DONE.
  - DONE: done=1. start=1 -> REQ, latching new base_addr, index=0, done=0 from the next cycle.
- Bytes 0..37 are read (38 reads); bytes 38..53 are never read. Multi-byte fields are little-endian.
- Cost per byte is RD_LATENCY+1 cycles. done rises 38*(RD_LATENCY+1)+1 edges after the start-accept edge: 77 edges for RD_LATENCY=1.
- rden is 0 outside REQ. addr holds its last value outside REQ.
- start is ignored in REQ, WAIT and CHECK.
- Reset mid-parse returns to IDLE. No further rden is issued. Outputs return to their reset values.
- Output registers update only on the CHECK->DONE edge and are otherwise stable.
- On error, width/height/stride/offset still load their raw truncated values, but consumers must ignore them.
- Height is a signed 32-bit value. top_down = bit 31. Absolute value = two's complement negation when negative.
- row_stride is computed from the 11-bit width at 13-bit precision with no overflow (max 6144).
- Error codes: lowest code wins when several checks fail.
  - 0 OK
  - 1 signature is not 0x42,0x4D
  - 2 DIB header size < 40
  - 3 planes != 1
  - 4 bpp != 24
  - 5 compression != 0
  - 6 width = 0 or > MAX_WIDTH (checked on the full 32-bit field, signed-negative counts as too large)
  - 7 height = 0 or |height| > MAX_HEIGHT
  - 8 data_offset < 54
  - 9 image-size field is nonzero and != row_stride*|height|
  - 10-15 reserved

Decomposition:
- Package bmp_pkg holds:
  - byte offset constants: SIG=0, FSIZE=2, OFFSET=10, DIBSZ=14, WIDTH=18, HEIGHT=22, PLANES=26, BPP=28, COMP=30, ISIZE=34
  - BMP_HDR_BYTES=54, PARSE_BYTES=38
  - the error-code enum, shared with the header generator
  - the state enum
- One sub-module, bmp_field_check, is combinational. It maps raw fields to error, stride, abs height and top_down. This keeps the FSM module sequencing-only and lets the checks be unit-tested alone.

Test Plan:
- 100x100 header (sig 42 4D, offset 54, DIB 40, planes 1, bpp 24, comp 0, isize 30000), RD_LATENCY=1 -> done at edge 77, error 0, width 100, height 100, stride 300, top_down 0, offset 54; exactly 38 rden pulses at addrs base..base+37.
- Width 3, height 0xFFFFFF9C (-100), isize 0 -> error 0, stride 12, height 100, top_down 1.
- Byte 1 = 0x4E and bpp = 32 -> error 1 (priority over 4). Same header with only bpp=32 -> error 4.
- Width 2048 -> error 6. isize 29999 with 100x100 -> error 9.
- rst_n low for one cycle at edge 20 of a parse -> IDLE, rden 0, all outputs 0. A new start completes normally. start pulses in REQ/WAIT are ignored with no restart.
- RD_LATENCY=3, base_addr 0x001000 -> done at edge 153, addrs 0x001000..0x001025, rddata[15:8] = 0xFF garbage causes no change in results.

Source files
------------

// File: rtl/bmp_pkg.sv
// bmp_pkg: header byte offsets, sizes, error codes and parser states shared by the BMP header blocks
package bmp_pkg;
    localparam int SIG    = 0;
    localparam int FSIZE  = 2;
    localparam int OFFSET = 10;
    localparam int DIBSZ  = 14;
    localparam int WIDTH  = 18;
    localparam int HEIGHT = 22;
    localparam int PLANES = 26;
    localparam int BPP    = 28;
    localparam int COMP   = 30;
    localparam int ISIZE  = 34;
    localparam int BMP_HDR_BYTES = 54;
    localparam int PARSE_BYTES   = 38;
    typedef enum logic [3:0] {
        ERR_OK       = 4'd0,
        ERR_SIG      = 4'd1,
        ERR_DIB_SIZE = 4'd2,
        ERR_PLANES   = 4'd3,
        ERR_BPP      = 4'd4,
        ERR_COMP     = 4'd5,
        ERR_WIDTH    = 4'd6,
        ERR_HEIGHT   = 4'd7,
        ERR_OFFSET   = 4'd8,
        ERR_ISIZE    = 4'd9
    } bmp_err_e;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_DONE} state_e;
endpackage

// File: rtl/bmp_header_parser_if.sv
// bmp_header_parser_if: start/base control, byte-read memory port and parse results
interface bmp_header_parser_if;
    logic              start;
    logic [23:0]       base_addr;
    logic [23:0]       addr;
    logic              rden;
    logic [15:0]       rddata;
    logic              busy;
    logic              done;
    bmp_pkg::bmp_err_e error;
    logic [10:0]       width;
    logic [10:0]       height;
    logic              top_down;
    logic [31:0]       data_offset;
    logic [12:0]       row_stride;
    modport master (
        input  start, base_addr, rddata,
        output addr, rden, busy, done, error, width, height, top_down, data_offset, row_stride
    );
    modport slave (
        output start, base_addr, rddata,
        input  addr, rden, busy, done, error, width, height, top_down, data_offset, row_stride
    );
endinterface

// File: rtl/bmp_field_check.sv
// bmp_field_check: validates raw BMP header fields and derives row stride, absolute height and orientation
module bmp_field_check
    import bmp_pkg::*;
#(
    parameter int MAX_WIDTH  = 2047,
    parameter int MAX_HEIGHT = 2047
) (
    input  logic [15:0] sig_i,
    input  logic [31:0] dib_size_i,
    input  logic [15:0] planes_i,
    input  logic [15:0] bpp_i,
    input  logic [31:0] comp_i,
    input  logic [31:0] width_i,
    input  logic [31:0] height_i,
    input  logic [31:0] offset_i,
    input  logic [31:0] isize_i,
    output bmp_err_e    error_o,
    output logic [12:0] stride_o,
    output logic [10:0] abs_height_o,
    output logic        top_down_o
);
    logic [31:0] abs_h;
    logic [12:0] row_bytes;
    logic [31:0] area;
    // unsigned compares make a negative width look oversized
    always_comb begin
        abs_h        = height_i[31] ? -height_i : height_i;
        row_bytes    = 13'(width_i[10:0]) * 13'd3 + 13'd3;
        stride_o     = row_bytes & ~13'd3;
        abs_height_o = abs_h[10:0];
        top_down_o   = height_i[31];
        area         = 32'(stride_o) * 32'(abs_h[10:0]);
        error_o      = sig_i != 16'h4D42                                 ? ERR_SIG      :
                       dib_size_i < 32'd40                               ? ERR_DIB_SIZE :
                       planes_i != 16'd1                                 ? ERR_PLANES   :
                       bpp_i != 16'd24                                   ? ERR_BPP      :
                       comp_i != 32'd0                                   ? ERR_COMP     :
                       width_i == 32'd0 || width_i > 32'(MAX_WIDTH)      ? ERR_WIDTH    :
                       height_i == 32'd0 || abs_h > 32'(MAX_HEIGHT)      ? ERR_HEIGHT   :
                       offset_i < 32'(BMP_HDR_BYTES)                     ? ERR_OFFSET   :
                       isize_i != 32'd0 && isize_i != area               ? ERR_ISIZE    :
                                                                           ERR_OK;
    end
endmodule

// File: rtl/bmp_header_parser.sv
// bmp_header_parser: reads header bytes 0..37 one at a time from fixed-latency memory and reports geometry plus a validation code
module bmp_header_parser
    import bmp_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int MAX_WIDTH  = 2047,
    parameter int MAX_HEIGHT = 2047
) (
    input logic                 clk,
    input logic                 rst_n,
    bmp_header_parser_if.master bus
);
    state_e      state_q, state_d;
    logic [23:0] base_q, base_d;
    logic [5:0]  idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  hdr_q [PARSE_BYTES];
    logic        last_cnt, last_byte;
    bmp_err_e    err_chk, err_q;
    logic [12:0] stride_chk, stride_q;
    logic [10:0] height_chk, height_q, width_q;
    logic        top_chk, top_q;
    logic [31:0] offset_q;

    function automatic logic [31:0] le32(input int b);
        return {hdr_q[b+3], hdr_q[b+2], hdr_q[b+1], hdr_q[b]};
    endfunction

    function automatic logic [15:0] le16(input int b);
        return {hdr_q[b+1], hdr_q[b]};
    endfunction

    assign last_cnt  = cnt_q == 2'(RD_LATENCY - 1);
    assign last_byte = idx_q == 6'(PARSE_BYTES - 1);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.start) begin
                state_d = S_REQ;
                base_d  = bus.base_addr;
                idx_d   = '0;
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d   = last_cnt ? cnt_q : cnt_q + 2'd1;
                state_d = !last_cnt ? S_WAIT : last_byte ? S_CHECK : S_REQ;
                idx_d   = last_cnt && !last_byte ? idx_q + 6'd1 : idx_q;
            end
            S_CHECK: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= ERR_OK;
            width_q  <= '0;
            height_q <= '0;
            top_q    <= 1'b0;
            offset_q <= '0;
            stride_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (state_q == S_CHECK) begin
                err_q    <= err_chk;
                width_q  <= {hdr_q[WIDTH+1][2:0], hdr_q[WIDTH]};
                height_q <= height_chk;
                top_q    <= top_chk;
                offset_q <= le32(OFFSET);
                stride_q <= stride_chk;
            end
        end
    end

    // the byte lands on the last wait cycle, when the fixed-latency data is valid
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT && last_cnt) hdr_q[idx_q] <= bus.rddata[7:0];
    end

    bmp_field_check #(.MAX_WIDTH(MAX_WIDTH), .MAX_HEIGHT(MAX_HEIGHT)) u_check (
        .sig_i       (le16(SIG)),
        .dib_size_i  (le32(DIBSZ)),
        .planes_i    (le16(PLANES)),
        .bpp_i       (le16(BPP)),
        .comp_i      (le32(COMP)),
        .width_i     (le32(WIDTH)),
        .height_i    (le32(HEIGHT)),
        .offset_i    (le32(OFFSET)),
        .isize_i     (le32(ISIZE)),
        .error_o     (err_chk),
        .stride_o    (stride_chk),
        .abs_height_o(height_chk),
        .top_down_o  (top_chk)
    );

    assign bus.addr        = base_q + 24'(idx_q);
    assign bus.rden        = state_q == S_REQ;
    assign bus.busy        = state_q inside {S_REQ, S_WAIT, S_CHECK};
    assign bus.done        = state_q == S_DONE;
    assign bus.error       = err_q;
    assign bus.width       = width_q;
    assign bus.height      = height_q;
    assign bus.top_down    = top_q;
    assign bus.data_offset = offset_q;
    assign bus.row_stride  = stride_q;
endmodule

// File: tb/tb_bmp_header_parser.sv
// tb_bmp_header_parser: drives the same headers into RD_LATENCY=1 and =3 parsers; scoreboards read addresses and results
module tb_bmp_header_parser;
    import bmp_pkg::*;

    typedef struct {
        logic [3:0]  err;
        logic [10:0] w;
        logic [10:0] h;
        logic        td;
        logic [31:0] off;
        logic [12:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [8192];
    logic [15:0] p1;
    logic [15:0] p3 [3];
    logic [23:0] aq1 [$];
    logic [23:0] aq3 [$];
    exp_t        eq1 [$];
    exp_t        eq3 [$];
    int          r1 = 0, r3 = 0;
    logic        d1 = 1'b0, d3 = 1'b0;

    bmp_header_parser_if b1 ();
    bmp_header_parser_if b3 ();

    bmp_header_parser #(.RD_LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
    bmp_header_parser #(.RD_LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.master));

    always #5 clk = ~clk;

    // fixed-latency memory; off-slot cycles return random bytes so a mistimed capture shows up
    always @(posedge clk) begin
        p1    <= {8'h00, b1.rden ? mem[b1.addr[12:0]] : 8'($urandom)};
        p3[0] <= {8'hFF, b3.rden ? mem[b3.addr[12:0]] : 8'($urandom)};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.rddata = p1;
    assign b3.rddata = p3[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string t, input logic [3:0] err, input logic [10:0] w, input logic [10:0] h,
                       input logic td, input logic [31:0] off, input logic [12:0] st, input exp_t e);
        check({t, "_error"}, err, e.err);
        check({t, "_width"}, w, e.w);
        check({t, "_height"}, h, e.h);
        check({t, "_top_down"}, td, e.td);
        check({t, "_offset"}, off, e.off);
        check({t, "_stride"}, st, e.st);
    endtask

    always @(posedge clk) begin
        #1;
        if (b1.rden) begin
            r1++;
            check("l1_rden_expected", aq1.size() != 0, 1);
            if (aq1.size() != 0) check("l1_addr", b1.addr, aq1.pop_front());
        end
        if (b3.rden) begin
            r3++;
            check("l3_rden_expected", aq3.size() != 0, 1);
            if (aq3.size() != 0) check("l3_addr", b3.addr, aq3.pop_front());
        end
        if (b1.done && !d1) begin
            check("l1_result_expected", eq1.size() != 0, 1);
            if (eq1.size() != 0)
                cmp("l1", b1.error, b1.width, b1.height, b1.top_down, b1.data_offset, b1.row_stride, eq1.pop_front());
        end
        if (b3.done && !d3) begin
            check("l3_result_expected", eq3.size() != 0, 1);
            if (eq3.size() != 0)
                cmp("l3", b3.error, b3.width, b3.height, b3.top_down, b3.data_offset, b3.row_stride, eq3.pop_front());
        end
        d1 = b1.done;
        d3 = b3.done;
    end

    function automatic exp_t mk(input logic [3:0] err, input int w, input int h, input logic td, input int off, input int st);
        exp_t e;
        e.err = err;
        e.w   = 11'(w);
        e.h   = 11'(h);
        e.td  = td;
        e.off = 32'(off);
        e.st  = 13'(st);
        return e;
    endfunction

    task automatic put(input int a, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) mem[a + i] = v[8*i +: 8];
    endtask

    task automatic hdr(input int b, input logic [7:0] s1, input logic [31:0] dib, input logic [31:0] planes,
                       input logic [31:0] bpp, input logic [31:0] comp, input logic [31:0] w, input logic [31:0] h,
                       input logic [31:0] off, input logic [31:0] isz);
        for (int i = 0; i < BMP_HDR_BYTES; i++) mem[b + i] = 8'($urandom);
        mem[b + SIG]     = 8'h42;
        mem[b + SIG + 1] = s1;
        put(b + OFFSET, off, 4);
        put(b + DIBSZ, dib, 4);
        put(b + WIDTH, w, 4);
        put(b + HEIGHT, h, 4);
        put(b + PLANES, planes, 2);
        put(b + BPP, bpp, 2);
        put(b + COMP, comp, 4);
        put(b + ISIZE, isz, 4);
    endtask

    task automatic drive_start(input logic s, input logic [23:0] base);
        b1.start = s;
        b3.start = s;
        b1.base_addr = base;
        b3.base_addr = base;
    endtask

    task automatic push_addrs(input logic [23:0] base);
        for (int i = 0; i < PARSE_BYTES; i++) begin
            aq1.push_back(base + 24'(i));
            aq3.push_back(base + 24'(i));
        end
    endtask

    task automatic parse(input logic [23:0] base, input exp_t e, input bit poke);
        int n = 0;
        int t1 = -1;
        int t3 = -1;
        @(negedge clk);
        drive_start(1'b1, base);
        r1 = 0;
        r3 = 0;
        push_addrs(base);
        eq1.push_back(e);
        eq3.push_back(e);
        @(posedge clk);
        while ((t1 < 0 || t3 < 0) && n < 400) begin
            #1;
            if (t1 < 0 && b1.done) t1 = n;
            if (t3 < 0 && b3.done) t3 = n;
            if (poke && (n == 6 || n == 7)) drive_start(1'b1, 24'hABCDEF);
            else drive_start(1'b0, base);
            if (t1 < 0 || t3 < 0) begin
                @(posedge clk);
                n++;
            end
        end
        #2;
        check("l1_done_edge", t1, 38 * 2 + 1);
        check("l3_done_edge", t3, 38 * 4 + 1);
        check("l1_rden_count", r1, PARSE_BYTES);
        check("l3_rden_count", r3, PARSE_BYTES);
        check("l1_addrs_left", aq1.size(), 0);
        check("l3_addrs_left", aq3.size(), 0);
        check("l1_results_left", eq1.size(), 0);
        check("l3_results_left", eq3.size(), 0);
    endtask

    task automatic zero(input string t);
        check({t, "_l1_ctl"}, {b1.addr, b1.rden, b1.busy, b1.done, b1.error}, 0);
        check({t, "_l1_geo"}, {b1.width, b1.height, b1.top_down, b1.row_stride, b1.data_offset}, 0);
        check({t, "_l3_ctl"}, {b3.addr, b3.rden, b3.busy, b3.done, b3.error}, 0);
        check({t, "_l3_geo"}, {b3.width, b3.height, b3.top_down, b3.row_stride, b3.data_offset}, 0);
    endtask

    initial begin
        drive_start(1'b0, 24'h0);
        repeat (3) @(posedge clk);
        #1 zero("reset");
        @(negedge clk) rst_n = 1'b1;

        hdr(24'h040, 8'h4D, 40, 1, 24, 0, 100, 100, 54, 30000);
        parse(24'h040, mk(0, 100, 100, 0, 54, 300), 0);
        hdr(24'h100, 8'h4D, 40, 1, 24, 0, 3, 32'hFFFFFF9C, 54, 0);
        parse(24'h100, mk(0, 3, 100, 1, 54, 12), 0);
        hdr(24'h200, 8'h4E, 40, 1, 32, 0, 100, 100, 54, 30000);
        parse(24'h200, mk(1, 100, 100, 0, 54, 300), 0);
        hdr(24'h200, 8'h4D, 40, 1, 32, 0, 100, 100, 54, 30000);
        parse(24'h200, mk(4, 100, 100, 0, 54, 300), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 2048, 100, 54, 30000);
        parse(24'h300, mk(6, 0, 100, 0, 54, 0), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 100, 100, 54, 29999);
        parse(24'h300, mk(9, 100, 100, 0, 54, 300), 0);
        hdr(24'h300, 8'h4D, 39, 1, 24, 0, 100, 100, 54, 30000);
        parse(24'h300, mk(2, 100, 100, 0, 54, 300), 0);
        hdr(24'h300, 8'h4D, 40, 2, 24, 0, 100, 100, 54, 30000);
        parse(24'h300, mk(3, 100, 100, 0, 54, 300), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 1, 100, 100, 54, 30000);
        parse(24'h300, mk(5, 100, 100, 0, 54, 300), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 100, 0, 54, 30000);
        parse(24'h300, mk(7, 100, 0, 0, 54, 300), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 100, 32'hFFFFF800, 54, 0);
        parse(24'h300, mk(7, 100, 0, 1, 54, 300), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 100, 100, 53, 30000);
        parse(24'h300, mk(8, 100, 100, 0, 53, 300), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 32'hFFFFFFFF, 100, 54, 30000);
        parse(24'h300, mk(6, 2047, 100, 0, 54, 6144), 0);
        hdr(24'h300, 8'h4D, 40, 1, 24, 0, 2047, 1, 54, 6144);
        parse(24'h300, mk(0, 2047, 1, 0, 54, 6144), 0);

        hdr(24'h400, 8'h4D, 40, 1, 24, 0, 100, 100, 54, 30000);
        parse(24'h400, mk(0, 100, 100, 0, 54, 300), 1);

        hdr(24'h500, 8'h4D, 40, 1, 24, 0, 5, 7, 60, 0);
        @(negedge clk);
        drive_start(1'b1, 24'h500);
        push_addrs(24'h500);
        @(posedge clk);
        #1 drive_start(1'b0, 24'h500);
        repeat (19) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 zero("midreset");
        aq1.delete();
        aq3.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("l1_idle_after_reset", {b1.busy, b1.done}, 0);
        check("l3_idle_after_reset", {b3.busy, b3.done}, 0);
        parse(24'h500, mk(0, 5, 7, 0, 60, 16), 0);

        hdr(24'h1000, 8'h4D, 40, 1, 24, 0, 100, 100, 54, 30000);
        parse(24'h001000, mk(0, 100, 100, 0, 54, 300), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
